shot_pool: RTL

- Multi-bullet successor to the single-shot builder/bullet drawer pair.
- Manages a parametrised pool of simultaneous shots fired from the gun position and moves them upward once per video frame.
- Reports per-slot position and liveness for collision logic.
- Emits a registered per-pixel draw flag and colour for the control drawer, so it can be used directly as its shot source.

---
 rtl/shot_pool.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/shot_pool.sv
// Pool of simultaneous upward-moving shots spawned at the gun position.
// Shots advance once per frame; a registered draw flag/colour feeds the control drawer.
`timescale 1ns/1ps
module shot_pool #(
    parameter int          NUM_SHOTS  = 4,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          SHOT_W     = 4,
    parameter int          SHOT_H     = 8,
    parameter int          SPEED      = 4,
    parameter int          START_Y    = 440,
    parameter int          COOLDOWN   = 8,
    parameter logic [5:0]  SHOT_COLOR = 6'b111100
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic                      fire,
    input  logic [9:0]                gun_x,
    input  logic [9:0]                hcount,
    input  logic [9:0]                vcount,
    input  logic [NUM_SHOTS-1:0]      kill,
    output logic [NUM_SHOTS-1:0]      active,
    output logic [10*NUM_SHOTS-1:0]   shots_x,
    output logic [10*NUM_SHOTS-1:0]   shots_y,
    output logic                      shot_draw,
    output logic [5:0]                shot_data,
    output logic                      fire_drop,
    output logic [7:0]                fire_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam logic [9:0]  L_X_MAX   = 10'(H_ACTIVE - SHOT_W);
    localparam logic [9:0]  L_V_TICK  = 10'(V_ACTIVE);
    localparam logic [9:0]  L_SPEED   = 10'(SPEED);
    localparam logic [9:0]  L_START_Y = 10'(START_Y);
    localparam logic [10:0] L_SHOT_W  = 11'(SHOT_W);
    localparam logic [10:0] L_SHOT_H  = 11'(SHOT_H);
    localparam logic [7:0]  L_COOL    = 8'(COOLDOWN);

    logic                 r_fire_s1;
    logic                 r_fire_s2;
    logic                 r_fire_d;
    logic [0:0]           r_state;
    logic [7:0]           r_cooldown;
    logic [7:0]           r_fire_count;
    logic                 r_fire_drop;
    logic                 r_shot_draw;
    logic [5:0]           r_shot_data;
    logic [NUM_SHOTS-1:0] r_active;
    logic [9:0]           r_x [NUM_SHOTS];
    logic [9:0]           r_y [NUM_SHOTS];

    logic                 w_fire_edge;
    logic                 w_frame_tick;
    logic [7:0]           w_cooldown_nxt;
    logic                 w_free_any;
    logic [2:0]           w_free_idx;
    logic                 w_resolve;
    logic                 w_accept;
    logic                 w_drop;
    logic [9:0]           w_spawn_x;
    logic [NUM_SHOTS-1:0] w_hit;
    logic                 w_draw_nxt;

    assign w_fire_edge    = r_fire_s2 & ~r_fire_d;
    assign w_frame_tick   = (vcount == L_V_TICK) && (hcount == 10'd0);
    assign w_cooldown_nxt = (r_cooldown != 8'd0) ? r_cooldown - 8'd1 : 8'd0;
    assign w_spawn_x      = (gun_x > L_X_MAX) ? L_X_MAX : gun_x;

    // Arm resolution sees the cooldown after this tick's decrement, so a
    // pending shot goes out exactly COOLDOWN frames after the previous one.
    assign w_resolve = w_frame_tick && (r_state == ST_ARMED) && (w_cooldown_nxt == 8'd0);
    assign w_accept  = w_resolve && w_free_any;
    assign w_drop    = w_resolve && !w_free_any;

    // Lowest-index slot free before this tick.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = 3'd0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_any = 1'b1;
                w_free_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            w_hit[i] = r_active[i]
                     && (hcount >= r_x[i]) && ({1'b0, hcount} < ({1'b0, r_x[i]} + L_SHOT_W))
                     && (vcount >= r_y[i]) && ({1'b0, vcount} < ({1'b0, r_y[i]} + L_SHOT_H));
        end
        w_draw_nxt = |w_hit;
    end

    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            r_fire_s1    <= 1'b0;
            r_fire_s2    <= 1'b0;
            r_fire_d     <= 1'b0;
            r_state      <= ST_IDLE;
            r_cooldown   <= 8'd0;
            r_fire_count <= 8'd0;
            r_fire_drop  <= 1'b0;
            r_shot_draw  <= 1'b0;
            r_shot_data  <= 6'd0;
        end else begin
            r_fire_s1   <= fire;
            r_fire_s2   <= r_fire_s1;
            r_fire_d    <= r_fire_s2;
            r_fire_drop <= w_drop;
            r_shot_draw <= w_draw_nxt;
            r_shot_data <= w_draw_nxt ? SHOT_COLOR : 6'd0;
            if (w_frame_tick) begin
                r_cooldown <= w_cooldown_nxt;
            end
            if (w_accept) begin
                r_cooldown   <= L_COOL;
                r_fire_count <= r_fire_count + 8'd1;
            end
            if (w_resolve) begin
                r_state <= ST_IDLE;
            end else if ((r_state == ST_IDLE) && w_fire_edge) begin
                r_state <= ST_ARMED;
            end
        end
    end

    // Kill beats movement; a spawn into a pre-tick free slot overrides both.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            r_active <= '0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                r_x[i] <= 10'd0;
                r_y[i] <= 10'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SHOTS; i++) begin
                if (w_frame_tick) begin
                    if (kill[i]) begin
                        r_active[i] <= 1'b0;
                    end else if (r_active[i]) begin
                        if (r_y[i] >= L_SPEED) begin
                            r_y[i] <= r_y[i] - L_SPEED;
                        end else begin
                            r_active[i] <= 1'b0;
                        end
                    end
                    if (w_accept && (w_free_idx == 3'(i))) begin
                        r_active[i] <= 1'b1;
                        r_x[i]      <= w_spawn_x;
                        r_y[i]      <= L_START_Y;
                    end
                end else if (kill[i]) begin
                    r_active[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_pack
        assign shots_x[10*g +: 10] = r_x[g];
        assign shots_y[10*g +: 10] = r_y[g];
    end

    assign active     = r_active;
    assign shot_draw  = r_shot_draw;
    assign shot_data  = r_shot_data;
    assign fire_drop  = r_fire_drop;
    assign fire_count = r_fire_count;

endmodule
